// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory port signals for mem_port_arbiter
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_u_b_h_w;
    logic        ls_ready;
    logic [31:0] ls_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_u_b_h_w;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        err;

    modport master (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_u_b_h_w,
        input  mem_ready, mem_rdata,
        output if_ready, if_rdata, ls_ready, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_u_b_h_w, err
    );

    modport slave (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_u_b_h_w,
        output mem_ready, mem_rdata,
        input  if_ready, if_rdata, ls_ready, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_u_b_h_w, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/load-store arbiter onto one memory port; ARB_TIMEOUT_EN adds a BUSY timeout with err
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] BUSY_IF = 3'd1;
    localparam logic [2:0] BUSY_LS = 3'd2;
    localparam logic [2:0] RESP_IF = 3'd3;
    localparam logic [2:0] RESP_LS = 3'd4;

    logic [2:0]  state;
    logic        last_grant;   // 1 = load/store was granted last
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic [2:0]  mem_u_b_h_w_q;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;
    logic        busy;
    logic        tmo_hit;

    assign busy = (state == BUSY_IF) || (state == BUSY_LS);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] tmo_cnt;
    logic          err_q;

    // mem_ready on the expiry cycle still counts as a normal completion
    assign tmo_hit = busy && !bus.mem_ready && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state == IDLE && (bus.if_req || bus.ls_req))
                tmo_cnt <= '0;
            else if (busy && !bus.mem_ready)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign tmo_hit = 1'b0;
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_u_b_h_w_q <= '0;
            if_rdata_q    <= '0;
            ls_rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req && (!bus.ls_req || last_grant)) begin
                        state         <= BUSY_IF;
                        last_grant    <= 1'b0;
                        mem_addr_q    <= bus.if_addr;
                        mem_wdata_q   <= '0;
                        mem_we_q      <= 1'b0;
                        mem_u_b_h_w_q <= 3'b010;
                    end else if (bus.ls_req) begin
                        state         <= BUSY_LS;
                        last_grant    <= 1'b1;
                        mem_addr_q    <= bus.ls_addr;
                        mem_wdata_q   <= bus.ls_wdata;
                        mem_we_q      <= bus.ls_we;
                        mem_u_b_h_w_q <= bus.ls_u_b_h_w;
                    end
                end
                BUSY_IF: begin
                    if (bus.mem_ready) begin
                        if_rdata_q <= bus.mem_rdata;
                        state      <= RESP_IF;
                    end else if (tmo_hit) begin
                        if_rdata_q <= '0;
                        state      <= RESP_IF;
                    end
                end
                BUSY_LS: begin
                    // stores never disturb the last load result
                    if (bus.mem_ready) begin
                        if (!mem_we_q)
                            ls_rdata_q <= bus.mem_rdata;
                        state <= RESP_LS;
                    end else if (tmo_hit) begin
                        if (!mem_we_q)
                            ls_rdata_q <= '0;
                        state <= RESP_LS;
                    end
                end
                RESP_IF, RESP_LS: state <= IDLE;
                default:          state <= IDLE;
            endcase
        end
    end

    assign bus.mem_req     = busy;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_u_b_h_w = mem_u_b_h_w_q;
    assign bus.if_ready    = (state == RESP_IF);
    assign bus.ls_ready    = (state == RESP_LS);
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ls_rdata    = ls_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rst, if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_ubhw, mem_ready, mem_rdata;
        logic [31:0] e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_ubhw, e_if_ready, e_if_rdata, e_ls_ready, e_ls_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic [31:0] r, ir, ia, lr, lw, la, ld, lu, mr, md,
        input logic [31:0] emr, emw, ema, emd, eu, eir, eid, elr, eld);
        vec_t t;
        t.rst = r; t.if_req = ir; t.if_addr = ia; t.ls_req = lr; t.ls_we = lw;
        t.ls_addr = la; t.ls_wdata = ld; t.ls_ubhw = lu; t.mem_ready = mr; t.mem_rdata = md;
        t.e_mem_req = emr; t.e_mem_we = emw; t.e_mem_addr = ema; t.e_mem_wdata = emd; t.e_ubhw = eu;
        t.e_if_ready = eir; t.e_if_rdata = eid; t.e_ls_ready = elr; t.e_ls_rdata = eld;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t t);
        rst            = t.rst[0];
        bus.if_req     = t.if_req[0];
        bus.if_addr    = t.if_addr;
        bus.ls_req     = t.ls_req[0];
        bus.ls_we      = t.ls_we[0];
        bus.ls_addr    = t.ls_addr;
        bus.ls_wdata   = t.ls_wdata;
        bus.ls_u_b_h_w = t.ls_ubhw[2:0];
        bus.mem_ready  = t.mem_ready[0];
        bus.mem_rdata  = t.mem_rdata;
    endtask

    initial begin
        localparam logic [31:0] A  = 32'h0000_0100;
        localparam logic [31:0] S  = 32'h8000_0004;
        localparam logic [31:0] W  = 32'h1234_5678;
        localparam logic [31:0] DB = 32'hDEAD_BEEF;
        localparam logic [31:0] CF = 32'hCAFE_0000;
        int n;
        checks = 0;
        errors = 0;

        // reset, single fetch, spurious mem_ready
        vecs.push_back(v(1, 0, 0,     0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0,  0, 0));
        vecs.push_back(v(0, 1, A,     0, 0, 0, 0, 0, 0, 0,            1, 0, A, 0, 2, 0, 0,  0, 0));
        vecs.push_back(v(0, 0, A,     0, 0, 0, 0, 0, 1, DB,           0, 0, A, 0, 2, 1, DB, 0, 0));
        vecs.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            0, 0, A, 0, 2, 0, DB, 0, 0));
        vecs.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, A, 0, 2, 0, DB, 0, 0));
        // store with 5 wait cycles; request inputs change during BUSY
        vecs.push_back(v(0, 0, 0,     1, 1, S, W, 1, 0, 0,            1, 1, S, W, 1, 0, DB, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(v(0, 1, 32'h0BAD_0000, 1, 0, 32'h0BAD_0000, 0, 7, 0, 0, 1, 1, S, W, 1, 0, DB, 0, 0));
        vecs.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 1, 32'hAAAA_5555, 0, 1, S, W, 1, 0, DB, 1, 0));
        vecs.push_back(v(0, 0, 0,     0, 0, 0, 0, 0, 0, 0,            0, 1, S, W, 1, 0, DB, 0, 0));
        // reset with requests and mem_ready high, then a continuous tie
        vecs.push_back(v(1, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 0,           0, 0, 0,       0,  0, 0, 0,            0, 0));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h1111_1111, 1, 0, 32'h200, 0,  2, 0, 0,            0, 0));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h1111_1111, 0, 0, 32'h200, 0,  2, 1, 32'h1111_1111, 0, 0));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h2222_2222, 0, 0, 32'h200, 0,  2, 0, 32'h1111_1111, 0, 0));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h2222_2222, 1, 0, 32'h300, CF, 4, 0, 32'h1111_1111, 0, 0));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h2222_2222, 0, 0, 32'h300, CF, 4, 0, 32'h1111_1111, 1, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h3333_3333, 0, 0, 32'h300, CF, 4, 0, 32'h1111_1111, 0, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h3333_3333, 1, 0, 32'h200, 0,  2, 0, 32'h1111_1111, 0, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h3333_3333, 0, 0, 32'h200, 0,  2, 1, 32'h3333_3333, 0, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h4444_4444, 0, 0, 32'h200, 0,  2, 0, 32'h3333_3333, 0, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h4444_4444, 1, 0, 32'h300, CF, 4, 0, 32'h3333_3333, 0, 32'h2222_2222));
        vecs.push_back(v(0, 1, 32'h200, 1, 0, 32'h300, CF, 4, 1, 32'h4444_4444, 0, 0, 32'h300, CF, 4, 0, 32'h3333_3333, 1, 32'h4444_4444));
        // reset on the second BUSY cycle abandons the fetch
        vecs.push_back(v(0, 0, 0,       0, 0, 0, 0, 0, 0, 0,           0, 0, 32'h300, CF, 4, 0, 32'h3333_3333, 0, 32'h4444_4444));
        vecs.push_back(v(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0,           1, 0, 32'h500, 0,  2, 0, 32'h3333_3333, 0, 32'h4444_4444));
        vecs.push_back(v(0, 0, 32'h500, 0, 0, 0, 0, 0, 0, 0,           1, 0, 32'h500, 0,  2, 0, 32'h3333_3333, 0, 32'h4444_4444));
        vecs.push_back(v(1, 1, 32'h500, 1, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0,       0, 0, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        drive(vecs[0]);
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
            chk($sformatf("v%0d mem_req", i),     32'(bus.mem_req),     vecs[i].e_mem_req);
            chk($sformatf("v%0d mem_we", i),      32'(bus.mem_we),      vecs[i].e_mem_we);
            chk($sformatf("v%0d mem_addr", i),    bus.mem_addr,         vecs[i].e_mem_addr);
            chk($sformatf("v%0d mem_wdata", i),   bus.mem_wdata,        vecs[i].e_mem_wdata);
            chk($sformatf("v%0d mem_u_b_h_w", i), 32'(bus.mem_u_b_h_w), vecs[i].e_ubhw);
            chk($sformatf("v%0d if_ready", i),    32'(bus.if_ready),    vecs[i].e_if_ready);
            chk($sformatf("v%0d if_rdata", i),    bus.if_rdata,         vecs[i].e_if_rdata);
            chk($sformatf("v%0d ls_ready", i),    32'(bus.ls_ready),    vecs[i].e_ls_ready);
            chk($sformatf("v%0d ls_rdata", i),    bus.ls_rdata,         vecs[i].e_ls_rdata);
            chk($sformatf("v%0d err", i),         32'(bus.err),         32'd0);
        end

`ifdef ARB_TIMEOUT_EN
        // load that completes, so the timeout's zero load is visible
        drive(v(0, 0, 0, 1, 0, 32'h40, 0, 2, 1, 32'h7777_7777, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step();
        bus.ls_req = 1'b0;
        step();
        chk("pre ls_rdata", bus.ls_rdata, 32'h7777_7777);
        step();
        // mem_ready never arrives
        bus.ls_req = 1'b1; bus.mem_ready = 1'b0;
        step();
        bus.ls_req = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && bus.mem_req; k++) begin
            n++;
            step();
        end
        chk("tmo mem_req cycles", 32'(n), 32'd8);
        chk("tmo ls_ready", 32'(bus.ls_ready), 32'd1);
        chk("tmo err", 32'(bus.err), 32'd1);
        chk("tmo ls_rdata", bus.ls_rdata, 32'd0);
        step();
        chk("tmo err clears", 32'(bus.err), 32'd0);
        // mem_ready on the expiry cycle wins
        bus.ls_req = 1'b1; bus.mem_rdata = 32'h9999_0001;
        step();
        bus.ls_req = 1'b0;
        for (int k = 0; k < 7; k++) step();
        chk("race mem_req", 32'(bus.mem_req), 32'd1);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        chk("race ls_ready", 32'(bus.ls_ready), 32'd1);
        chk("race err", 32'(bus.err), 32'd0);
        chk("race ls_rdata", bus.ls_rdata, 32'h9999_0001);
`else
        // without the timeout a stalled fetch waits as long as it takes
        bus.mem_ready = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h600; bus.ls_req = 1'b0;
        step();
        bus.if_req = 1'b0;
        for (int k = 0; k < 40; k++) step();
        chk("stall mem_req", 32'(bus.mem_req), 32'd1);
        chk("stall if_ready", 32'(bus.if_ready), 32'd0);
        chk("stall err", 32'(bus.err), 32'd0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
        step();
        bus.mem_ready = 1'b0;
        chk("stall done if_ready", 32'(bus.if_ready), 32'd1);
        chk("stall done if_rdata", bus.if_rdata, 32'h0BAD_F00D);
        chk("stall done err", 32'(bus.err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
